// File: rtl/sprite_pkg.sv
// Shared pixel colour type and screen constants for the sprite compositor.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int TRANSPARENT_IDX = 0;
  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;

endpackage

// File: rtl/palette_ram.sv
// Colour palette: one write port, one registered read-first read port (read data one re_i clock later).
// No backpressure; writes land whenever we_i is high, the read register holds while re_i is low.
module palette_ram #(
  parameter int AW = 5,
  parameter int DW = 12
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: per-layer hit/ROM address, priority select, palette or background colour.
// Latency 3 pixel_en strobes, all state holds while pixel_en is low; SPRITE_COMPOSITOR_COLLISION_EN adds the layer-0/1 collision flag.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int SPR_W      = 128,
  parameter int SPR_H      = 128,
  parameter int IDX_W      = 5,
  parameter int COORD_W    = 10
) (
  input  logic                                                  Clk,
  input  logic                                                  Reset_n,
  input  logic                                                  pixel_en,
  input  logic                                                  frame_start,
  input  logic [COORD_W-1:0]                                    DrawX,
  input  logic [COORD_W-1:0]                                    DrawY,
  input  logic                                                  blank_in,
  input  logic [NUM_LAYERS-1:0][COORD_W-1:0]                    spr_x,
  input  logic [NUM_LAYERS-1:0][COORD_W-1:0]                    spr_y,
  input  logic [NUM_LAYERS-1:0]                                 spr_on,
  output logic [NUM_LAYERS-1:0][$clog2(SPR_W)+$clog2(SPR_H)-1:0] rom_addr,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0]                      rom_data,
  input  logic                                                  pal_we,
  input  logic [IDX_W-1:0]                                      pal_addr,
  input  logic [11:0]                                           pal_wdata,
  input  logic [11:0]                                           bg_rgb,
  output logic [3:0]                                            Red,
  output logic [3:0]                                            Green,
  output logic [3:0]                                            Blue,
  output logic                                                  blank_out,
  output logic                                                  collision
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSPARENT_IDX);

  // Positions only change at vertical sync so a frame is never torn.
  logic [NUM_LAYERS-1:0][COORD_W-1:0] sh_x_q, sh_y_q;
  logic [NUM_LAYERS-1:0]              sh_on_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sh_x_q  <= '0;
      sh_y_q  <= '0;
      sh_on_q <= '0;
    end else if (frame_start) begin
      sh_x_q  <= spr_x;
      sh_y_q  <= spr_y;
      sh_on_q <= spr_on;
    end
  end

  // One extra bit so a sprite near the right/bottom edge never wraps to column/row 0.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] start,
                                   input int                 size);
    logic [COORD_W:0] p_ext, lo, hi;
    p_ext = {1'b0, pos};
    lo    = {1'b0, start};
    hi    = lo + (COORD_W+1)'(size);
    return (p_ext >= lo) && (p_ext < hi);
  endfunction

  // Stage 1: hit test; the address goes out now so ROM data meets the hit bits at stage 2.
  logic [NUM_LAYERS-1:0]         hit_d, hit_q;
  logic [NUM_LAYERS-1:0][XW-1:0] dx_d;
  logic [NUM_LAYERS-1:0][YW-1:0] dy_d;

  always_comb begin
    hit_d    = '0;
    dx_d     = '0;
    dy_d     = '0;
    rom_addr = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      dx_d[l]  = XW'(DrawX - sh_x_q[l]);
      dy_d[l]  = YW'(DrawY - sh_y_q[l]);
      hit_d[l] = sh_on_q[l] && in_span(DrawX, sh_x_q[l], SPR_W)
                            && in_span(DrawY, sh_y_q[l], SPR_H);
      if (hit_d[l]) rom_addr[l] = {dy_d[l], dx_d[l]};
    end
  end

  logic blank1_q, blank2_q, blank3_q, bg2_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_q    <= '0;
      blank1_q <= 1'b0;
    end else if (pixel_en) begin
      hit_q    <= hit_d;
      blank1_q <= blank_in;
    end
  end

  // Stage 2: lowest-numbered opaque layer wins, so scan from the top down.
  logic [IDX_W-1:0] sel_idx_d;
  logic             sel_bg_d;

  always_comb begin
    sel_idx_d = '0;
    sel_bg_d  = 1'b1;
    for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
      if (hit_q[l] && (rom_data[l] != TRANSP)) begin
        sel_idx_d = rom_data[l];
        sel_bg_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bg2_q    <= 1'b1;
      blank2_q <= 1'b0;
    end else if (pixel_en) begin
      bg2_q    <= sel_bg_d;
      blank2_q <= blank1_q;
    end
  end

  logic [11:0] pal_rdata;

  palette_ram #(
    .AW (IDX_W),
    .DW (12)
  ) u_palette (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_wdata),
    .re_i    (pixel_en),
    .raddr_i (sel_idx_d),
    .rdata_o (pal_rdata)
  );

  // Stage 3: colour or background, blacked out outside active video.
  rgb12_t rgb_d, rgb_q;

  always_comb begin
    rgb_d = '0;
    if (blank2_q) rgb_d = bg2_q ? rgb12_t'(bg_rgb) : rgb12_t'(pal_rdata);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q    <= '0;
      blank3_q <= 1'b0;
    end else if (pixel_en) begin
      rgb_q    <= rgb_d;
      blank3_q <= blank2_q;
    end
  end

  assign Red       = rgb_q.r;
  assign Green     = rgb_q.g;
  assign Blue      = rgb_q.b;
  assign blank_out = blank3_q;

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  logic coll_q, both_opaque;

  assign both_opaque = blank1_q && hit_q[0] && hit_q[1] &&
                       (rom_data[0] != TRANSP) && (rom_data[1] != TRANSP);

  // A set in the same cycle as frame_start takes precedence over the clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                     coll_q <= 1'b0;
    else if (pixel_en && both_opaque) coll_q <= 1'b1;
    else if (frame_start)             coll_q <= 1'b0;
  end

  assign collision = coll_q;
`else
  assign collision = 1'b0;
`endif

endmodule
